// File: rtl/sudoku_pkg.sv
// Shared constants, state codes and cursor helper for the sudoku front panel,
// solver and board store.
package sudoku_pkg;

  localparam int CELL_NUM  = 81;
  localparam int ADDR_W    = 7;
  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  localparam logic [ADDR_W-1:0]  LAST_CELL = ADDR_W'(CELL_NUM - 1);
  localparam logic [DIGIT_W-1:0] TOP_DIGIT = DIGIT_W'(MAX_DIGIT);

  localparam logic [2:0] ST_EDIT    = 3'd0;
  localparam logic [2:0] ST_WRITE   = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_SOLVING = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;

  typedef enum logic [2:0] {
    EDIT    = ST_EDIT,
    WRITE   = ST_WRITE,
    START   = ST_START,
    SOLVING = ST_SOLVING,
    DONE    = ST_DONE,
    FAIL    = ST_FAIL
  } state_t;

  // Button indices into pb[4:0]
  localparam int PB_NEXT  = 0;
  localparam int PB_PREV  = 1;
  localparam int PB_DIGIT = 2;
  localparam int PB_WRITE = 3;
  localparam int PB_SOLVE = 4;

  // Cursor step with wrap across the 81 cells
  function automatic logic [ADDR_W-1:0] step_cursor(input logic [ADDR_W-1:0] cur,
                                                    input logic up);
    if (up) return (cur == LAST_CELL) ? '0 : cur + 1'b1;
    else    return (cur == '0) ? LAST_CELL : cur - 1'b1;
  endfunction

endpackage

// File: rtl/sudoku_ui_ctrl_if.sv
// Board-store write handshake and solver control bundle; master = UI controller.
interface sudoku_ui_ctrl_if;
  import sudoku_pkg::*;

  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DIGIT_W-1:0] wr_data;
  logic               solver_start;
  logic               solver_busy;
  logic               solver_done;
  logic               solver_fail;

  modport master (
    output wr_valid, wr_addr, wr_data, solver_start,
    input  wr_ready, solver_busy, solver_done, solver_fail
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, solver_start,
    output wr_ready, solver_busy, solver_done, solver_fail
  );
endinterface

// File: rtl/sudoku_ui_ctrl_pb_debounce.sv
// Push-button debouncer: 2-flop synchroniser, stable-high counter, one press
// pulse per hold; re-arms only after the button is released.
module pb_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (!sync[1]) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt   <= cnt + 1'b1;
        press <= (cnt == LIMIT - 1'b1);
      end
    end
  end
endmodule

// File: rtl/sudoku_ui_ctrl.sv
// Front-panel controller: debounced buttons drive cursor/digit edit, cell writes
// and solver start. Optional status blink: define SUDOKU_UI_BLINK_EN.
module sudoku_ui_ctrl
  import sudoku_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_CYCLES    = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        pb,
  output logic [11:0]       led,
  sudoku_ui_ctrl_if.master  bus
);
  if (DEBOUNCE_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_param_check
    $error("sudoku_ui_ctrl: DEBOUNCE_CYCLES must be >= 2 and BLINK_CYCLES >= 1");
  end

  logic [4:0] press;

  for (genvar i = 0; i < 5; i++) begin : g_db
    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (pb[i]),
      .press (press[i])
    );
  end

  state_t             state;
  logic [ADDR_W-1:0]  cursor;
  logic [DIGIT_W-1:0] digit;
  logic               status;
  logic               wr_valid;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DIGIT_W-1:0] wr_data;
  logic               solver_start;

`ifdef SUDOKU_UI_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_tick;
  assign blink_tick = (blink_cnt == BLINK_W'(BLINK_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EDIT;
      cursor       <= '0;
      digit        <= '0;
      status       <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      solver_start <= 1'b0;
`ifdef SUDOKU_UI_BLINK_EN
      blink_cnt    <= '0;
`endif
    end else begin
`ifdef SUDOKU_UI_BLINK_EN
      // Cleared every cycle except while a blinking state holds, so each
      // state entry starts a fresh half-period.
      blink_cnt <= '0;
`endif
      unique case (state)
        EDIT: begin
          if (press[PB_SOLVE]) begin
            state        <= START;
            solver_start <= 1'b1;
            status       <= 1'b1;
          end else if (press[PB_WRITE]) begin
            state    <= WRITE;
            wr_valid <= 1'b1;
            wr_addr  <= cursor;
            wr_data  <= digit;
          end else if (press[PB_DIGIT]) begin
            digit <= (digit == TOP_DIGIT) ? '0 : digit + 1'b1;
          end else if (press[PB_PREV]) begin
            cursor <= step_cursor(cursor, 1'b0);
          end else if (press[PB_NEXT]) begin
            cursor <= step_cursor(cursor, 1'b1);
          end
        end
        WRITE: begin
          if (bus.wr_ready) begin
            wr_valid <= 1'b0;
            state    <= EDIT;
          end
        end
        START: begin
          if (bus.solver_busy) begin
            solver_start <= 1'b0;
            state        <= SOLVING;
          end
        end
        SOLVING: begin
          if (bus.solver_fail) begin
            state  <= FAIL;
            status <= 1'b0;
          end else if (bus.solver_done) begin
            state  <= DONE;
            status <= 1'b1;
          end else begin
`ifdef SUDOKU_UI_BLINK_EN
            if (blink_tick) status    <= ~status;
            else            blink_cnt <= blink_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          if (press[PB_SOLVE]) begin
            state  <= EDIT;
            status <= 1'b0;
          end
        end
        FAIL: begin
          if (press[PB_SOLVE]) begin
            state  <= EDIT;
            status <= 1'b0;
          end else begin
`ifdef SUDOKU_UI_BLINK_EN
            if (blink_tick) status    <= ~status;
            else            blink_cnt <= blink_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state  <= EDIT;
          status <= 1'b0;
        end
      endcase
    end
  end

  assign led              = {status, digit, cursor};
  assign bus.wr_valid     = wr_valid;
  assign bus.wr_addr      = wr_addr;
  assign bus.wr_data      = wr_data;
  assign bus.solver_start = solver_start;
endmodule

// File: tb/tb_sudoku_ui_ctrl.sv
// Directed bench for sudoku_ui_ctrl: vector table for edit moves, hand-written
// sequences for write handshake, solver flow, blink and async reset.
module tb_sudoku_ui_ctrl;
  import sudoku_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  pb;
  logic [11:0] led;
  int          total = 0;
  int          bad   = 0;

  sudoku_ui_ctrl_if bus ();

  sudoku_ui_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pb    (pb),
    .led   (led),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pb;
    int         hold;
    logic [6:0] cursor;
    logic [3:0] digit;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] b, input int hold);
    @(negedge clk) pb = b;
    repeat (hold) @(negedge clk);
    pb = '0;
    repeat (6) @(negedge clk);
  endtask

  // which: 0 = wait for wr_valid high, 1 = solver_start high, 2 = solver_start low
  task automatic wait_sig(input int which, input string name);
    int n = 0;
    logic v;
    v = (which == 0) ? bus.wr_valid : (which == 1) ? bus.solver_start : !bus.solver_start;
    while (!v && n < 30) begin
      @(negedge clk);
      n++;
      v = (which == 0) ? bus.wr_valid : (which == 1) ? bus.solver_start : !bus.solver_start;
    end
    check(name, {31'd0, v}, 32'd1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{5'b00001, 10, 7'd1,  4'd0};
    vecs[1] = '{5'b00001,  2, 7'd1,  4'd0};  // glitch: too short
    vecs[2] = '{5'b00010, 10, 7'd0,  4'd0};
    vecs[3] = '{5'b00010, 10, 7'd80, 4'd0};  // wrap 0 -> 80
    vecs[4] = '{5'b00001, 10, 7'd0,  4'd0};  // wrap 80 -> 0
    vecs[5] = '{5'b00011, 10, 7'd80, 4'd0};  // pb1 beats pb0
    vecs[6] = '{5'b00101, 10, 7'd80, 4'd1};  // pb2 beats pb0
    vecs[7] = '{5'b00100, 10, 7'd80, 4'd2};
    vecs[8] = '{5'b00100, 10, 7'd80, 4'd3};
    vecs[9] = '{5'b00001, 10, 7'd0,  4'd3};

    pb = '0;
    bus.wr_ready    = 1'b0;
    bus.solver_busy = 1'b0;
    bus.solver_done = 1'b0;
    bus.solver_fail = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", {20'd0, led}, 32'd0);
    check("reset_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
    check("reset_start", {31'd0, bus.solver_start}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      press(vecs[i].pb, vecs[i].hold);
      check($sformatf("vec%0d_led", i), {20'd0, led},
            {20'd0, 1'b0, vecs[i].digit, vecs[i].cursor});
    end

    // 82 long presses of next-cell: one step each, wrapping 80 -> 0
    for (int i = 0; i < 82; i++) begin
      press(5'b00001, 10);
      check($sformatf("walk%0d_cursor", i), {25'd0, led[6:0]}, (i + 1) % 81);
    end
    check("walk_digit", {28'd0, led[10:7]}, 32'd3);

    // Write with board store stalling for 5 cycles
    @(negedge clk) pb = 5'b01000;
    wait_sig(0, "wr_valid_seen");
    pb = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wr_hold%0d_valid", i), {31'd0, bus.wr_valid}, 32'd1);
      check($sformatf("wr_hold%0d_addr", i), {25'd0, bus.wr_addr}, 32'd1);
      check($sformatf("wr_hold%0d_data", i), {28'd0, bus.wr_data}, 32'd3);
      if (i < 4) @(negedge clk);
    end
    bus.wr_ready = 1'b1;
    @(negedge clk);
    bus.wr_ready = 1'b0;
    check("wr_drop", {31'd0, bus.wr_valid}, 32'd0);
    repeat (6) @(negedge clk);
    check("wr_led", {20'd0, led}, {20'd0, 1'b0, 4'd3, 7'd1});

    // Digit wrap 9 -> 0 after 7 more increments from 3
    for (int i = 0; i < 7; i++) press(5'b00100, 10);
    check("digit_wrap", {20'd0, led}, {20'd0, 1'b0, 4'd0, 7'd1});
    press(5'b00100, 10);
    press(5'b00100, 10);
    check("digit_two", {28'd0, led[10:7]}, 32'd2);

    // Solve: start held until busy, then done
    @(negedge clk) pb = 5'b10000;
    wait_sig(1, "start_seen");
    check("start_status", {31'd0, led[11]}, 32'd1);
    repeat (3) @(negedge clk);
    check("start_held", {31'd0, bus.solver_start}, 32'd1);
    bus.solver_busy = 1'b1;
    @(negedge clk);
    check("start_drop", {31'd0, bus.solver_start}, 32'd0);
    check("solving_status", {31'd0, led[11]}, 32'd1);
    pb = '0;
    repeat (6) @(negedge clk);
    bus.solver_done = 1'b1;
    @(negedge clk);
    bus.solver_done = 1'b0;
    bus.solver_busy = 1'b0;
    check("done_status", {31'd0, led[11]}, 32'd1);
    press(5'b00001, 10);
    check("done_ignores_pb0", {20'd0, led}, {20'd0, 1'b1, 4'd2, 7'd1});
    press(5'b10000, 10);
    check("done_ack", {20'd0, led}, {20'd0, 1'b0, 4'd2, 7'd1});

    // done pulse outside SOLVING is ignored; still editing afterwards
    @(negedge clk) bus.solver_done = 1'b1;
    @(negedge clk) bus.solver_done = 1'b0;
    check("stray_done", {20'd0, led}, {20'd0, 1'b0, 4'd2, 7'd1});
    press(5'b00001, 10);
    check("edit_after_stray", {20'd0, led}, {20'd0, 1'b0, 4'd2, 7'd2});

    // done and fail together -> FAIL; buttons other than pb4 ignored
    @(negedge clk) pb = 5'b10000;
    wait_sig(1, "start2_seen");
    bus.solver_busy = 1'b1;
    wait_sig(2, "start2_drop");
    pb = '0;
    repeat (6) @(negedge clk);
    bus.solver_done = 1'b1;
    bus.solver_fail = 1'b1;
    @(negedge clk);
    bus.solver_done = 1'b0;
    bus.solver_fail = 1'b0;
    bus.solver_busy = 1'b0;
    check("fail_status", {31'd0, led[11]}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      press(5'(1 << b), 10);
      check($sformatf("fail_ignores_pb%0d", b), {21'd0, led[10:0]}, {21'd0, 4'd2, 7'd2});
      check($sformatf("fail_no_write_pb%0d", b), {31'd0, bus.wr_valid}, 32'd0);
    end
`ifdef SUDOKU_UI_BLINK_EN
    begin
      logic last;
      int   n;
      for (int h = 0; h < 2; h++) begin
        last = led[11];
        n = 0;
        while (led[11] == last && n < 40) begin
          @(negedge clk);
          n++;
        end
        if (h == 1) check("blink_half_period", n, 32'd8);
      end
    end
`endif
    press(5'b10000, 10);
    check("fail_ack", {20'd0, led}, {20'd0, 1'b0, 4'd2, 7'd2});

    // Async reset mid-WRITE
    @(negedge clk) pb = 5'b01000;
    wait_sig(0, "wr2_seen");
    pb = '0;
    async_reset();
    check("rst_write_valid", {31'd0, bus.wr_valid}, 32'd0);
    check("rst_write_led", {20'd0, led}, 32'd0);
    release_reset();
    bus.wr_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("no_pending_write", {31'd0, bus.wr_valid}, 32'd0);
    bus.wr_ready = 1'b0;
    press(5'b00010, 10);
    check("cursor_after_reset", {20'd0, led}, {20'd0, 1'b0, 4'd0, 7'd80});

    // Async reset mid-START
    @(negedge clk) pb = 5'b10000;
    wait_sig(1, "start3_seen");
    pb = '0;
    async_reset();
    check("rst_start_start", {31'd0, bus.solver_start}, 32'd0);
    check("rst_start_led", {20'd0, led}, 32'd0);
    release_reset();

    // Async reset mid-SOLVING
    repeat (6) @(negedge clk);
    @(negedge clk) pb = 5'b10000;
    wait_sig(1, "start4_seen");
    bus.solver_busy = 1'b1;
    wait_sig(2, "start4_drop");
    pb = '0;
    check("solving4_status", {31'd0, led[11]}, 32'd1);
    async_reset();
    check("rst_solving_start", {31'd0, bus.solver_start}, 32'd0);
    check("rst_solving_led", {20'd0, led}, 32'd0);
    bus.solver_busy = 1'b0;
    release_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
